// File: rtl/sound_frame_seq.sv
// -----------------------------------------------------------------------------
// sound_frame_seq
//
// APU frame sequencer. Turns a 512 Hz timebase into one-cycle enable ticks
// for the channel length counters (256 Hz), the channel 1 sweep unit (128 Hz)
// and the envelope units (64 Hz). Gated by the NR52 master enable (apu_en).
//
// Timebase source:
//   default              : falling edge of div_bit (DIV bit 12 / bit 13 in
//                          double speed), single-sample edge detect.
//   SOUND_FS_INTDIV_EN   : when this macro is defined, div_bit is ignored and
//                          an internal DIV_WIDTH-bit prescaler produces one
//                          event every DIV_MAX+1 clocks while apu_en is high.
//
// Ticks are registered: an event in cycle N executes the step held during N,
// raises its ticks for cycle N+1 only, and advances the step at the end of N.
// -----------------------------------------------------------------------------
module sound_frame_seq #(
    parameter int DIV_WIDTH = 13,
    parameter int DIV_MAX   = 8191
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apu_en,
    input  logic       div_bit,
    output logic [2:0] step,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       len_phase
);

    // Step index of the frame sequencer; the name encodes what executes.
    typedef enum logic [2:0] {
        STEP0_LEN     = 3'd0,
        STEP1_IDLE    = 3'd1,
        STEP2_LEN_SWP = 3'd2,
        STEP3_IDLE    = 3'd3,
        STEP4_LEN     = 3'd4,
        STEP5_IDLE    = 3'd5,
        STEP6_LEN_SWP = 3'd6,
        STEP7_ENV     = 3'd7
    } step_e;

    step_e      step_q, step_d;
    logic [2:0] step_bits;

    logic       div_bit_q;
    logic       fs_evt;

    logic       len_tick_q, len_tick_d;
    logic       swp_tick_q, swp_tick_d;
    logic       env_tick_q, env_tick_d;

    // Elaboration-time sanity check on the prescaler configuration.
    if (DIV_WIDTH < 1 || DIV_WIDTH > 30 || DIV_MAX < 1 ||
        DIV_MAX > ((1 << DIV_WIDTH) - 1)) begin : g_bad_cfg
        $error("sound_frame_seq: DIV_MAX does not fit in DIV_WIDTH bits");
    end

    // Registered copy of div_bit for edge detection; tracks even when powered off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_bit_q <= 1'b0;
        end else begin
            div_bit_q <= div_bit;
        end
    end

`ifdef SOUND_FS_INTDIV_EN
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 presc_wrap;

    // Prescaler next value: count while powered, wrap at terminal count.
    always_comb begin
        presc_wrap = (presc_q == DIV_WIDTH'(DIV_MAX));
        presc_d    = presc_q + 1'b1;
        if (!apu_en || presc_wrap) begin
            presc_d = '0;
        end
    end

    // Prescaler register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign fs_evt = apu_en & presc_wrap;
`else
    assign fs_evt = div_bit_q & ~div_bit & apu_en;
`endif

    // Sequencer state register plus the registered tick outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q     <= STEP0_LEN;
            len_tick_q <= 1'b0;
            swp_tick_q <= 1'b0;
            env_tick_q <= 1'b0;
        end else begin
            step_q     <= step_d;
            len_tick_q <= len_tick_d;
            swp_tick_q <= swp_tick_d;
            env_tick_q <= env_tick_d;
        end
    end

    // Next step: power-off forces step 0, an event advances with 3-bit wrap.
    always_comb begin
        step_d = step_q;
        if (!apu_en) begin
            step_d = STEP0_LEN;
        end else if (fs_evt) begin
            step_d = step_e'(step_q + 3'd1);
        end
    end

    // Tick decode for the step executing this cycle; zero without an event.
    always_comb begin
        len_tick_d = 1'b0;
        swp_tick_d = 1'b0;
        env_tick_d = 1'b0;
        if (fs_evt) begin
            unique case (step_q)
                STEP0_LEN, STEP4_LEN: begin
                    len_tick_d = 1'b1;
                end
                STEP2_LEN_SWP, STEP6_LEN_SWP: begin
                    len_tick_d = 1'b1;
                    swp_tick_d = 1'b1;
                end
                STEP7_ENV: begin
                    env_tick_d = 1'b1;
                end
                default: begin
                    len_tick_d = 1'b0;
                end
            endcase
        end
    end

    assign step_bits   = step_q;
    assign step        = step_bits;
    assign len_phase   = step_bits[0];
    assign length_tick = len_tick_q;
    assign sweep_tick  = swp_tick_q;
    assign env_tick    = env_tick_q;

endmodule

// File: tb/tb_sound_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_sound_frame_seq
//
// Directed bench for sound_frame_seq. Inputs are driven on the falling clock
// edge and outputs sampled on the falling edge, half a cycle from the active
// edge. With SOUND_FS_INTDIV_EN defined, only the reset and internal
// prescaler scenarios run, since div_bit is ignored in that build.
// -----------------------------------------------------------------------------
module tb_sound_frame_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       apu_en;
    logic       div_bit;
    logic [2:0] step;
    logic       length_tick;
    logic       sweep_tick;
    logic       env_tick;
    logic       len_phase;

    int vec     = 0;
    int miscmp  = 0;

    sound_frame_seq #(
        .DIV_WIDTH (13),
        .DIV_MAX   (8191)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .apu_en      (apu_en),
        .div_bit     (div_bit),
        .step        (step),
        .length_tick (length_tick),
        .sweep_tick  (sweep_tick),
        .env_tick    (env_tick),
        .len_phase   (len_phase)
    );

    always #5 clk = ~clk;

    // One div_bit falling edge; returns {length,sweep,env} seen in the tick cycle.
    task automatic fs_edge(output logic [2:0] t);
        div_bit = 1'b1;
        @(negedge clk);
        vec++;
        if ({length_tick, sweep_tick, env_tick} !== 3'b000) begin
            miscmp++;
            $display("FAIL pre_edge_ticks: got %b expected 000",
                     {length_tick, sweep_tick, env_tick});
        end
        div_bit = 1'b0;
        @(negedge clk);
        t = {length_tick, sweep_tick, env_tick};
        @(negedge clk);
        vec++;
        if ({length_tick, sweep_tick, env_tick} !== 3'b000) begin
            miscmp++;
            $display("FAIL tick_width: got %b expected 000 one cycle after tick",
                     {length_tick, sweep_tick, env_tick});
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        apu_en  = 1'b0;
        div_bit = 1'b0;
        #1;
        vec++;
        if ({step, length_tick, sweep_tick, env_tick, len_phase} !== 7'b0) begin
            miscmp++;
            $display("FAIL reset_state: got %b expected 0000000",
                     {step, length_tick, sweep_tick, env_tick, len_phase});
        end
        // Activity while reset is held must not leak through.
        @(negedge clk);
        apu_en  = 1'b1;
        div_bit = 1'b1;
        @(negedge clk);
        div_bit = 1'b0;
        @(negedge clk);
        vec++;
        if ({step, length_tick, sweep_tick, env_tick, len_phase} !== 7'b0) begin
            miscmp++;
            $display("FAIL reset_held: got %b expected 0000000",
                     {step, length_tick, sweep_tick, env_tick, len_phase});
        end
        rst = 1'b0;
    endtask

    task automatic test_sequence;
        logic [7:0] len_exp;
        logic [7:0] swp_exp;
        logic [7:0] env_exp;
        logic [2:0] t;
        logic [2:0] s;
        len_exp = 8'b0101_0101;   // edges 1,3,5,7
        swp_exp = 8'b0100_0100;   // edges 3,7
        env_exp = 8'b1000_0000;   // edge 8
        for (int i = 0; i < 8; i++) begin
            fs_edge(t);
            vec++;
            if (t !== {len_exp[i], swp_exp[i], env_exp[i]}) begin
                miscmp++;
                $display("FAIL seq_ticks edge %0d: got %b expected %b",
                         i + 1, t, {len_exp[i], swp_exp[i], env_exp[i]});
            end
            s = 3'((i + 1) % 8);
            vec++;
            if ({step, len_phase} !== {s, s[0]}) begin
                miscmp++;
                $display("FAIL seq_step edge %0d: got step=%0d lp=%b expected step=%0d lp=%b",
                         i + 1, step, len_phase, s, s[0]);
            end
        end
    endtask

    task automatic test_counts;
        int n_len;
        int n_swp;
        int n_env;
        logic [2:0] t;
        logic [2:0] s;
        s = 3'd0;
        for (int w = 0; w < 2; w++) begin
            n_len = 0;
            n_swp = 0;
            n_env = 0;
            for (int i = 0; i < 8; i++) begin
                fs_edge(t);
                n_len += int'(t[2]);
                n_swp += int'(t[1]);
                n_env += int'(t[0]);
                s = s + 3'd1;
                vec++;
                if (len_phase !== s[0] || step !== s) begin
                    miscmp++;
                    $display("FAIL count_phase: got step=%0d lp=%b expected step=%0d lp=%b",
                             step, len_phase, s, s[0]);
                end
            end
            vec++;
            if (n_len != 4 || n_swp != 2 || n_env != 1) begin
                miscmp++;
                $display("FAIL window_counts %0d: got len=%0d swp=%0d env=%0d expected 4 2 1",
                         w, n_len, n_swp, n_env);
            end
        end
    endtask

    task automatic test_power_off;
        logic [2:0] t;
        for (int i = 0; i < 5; i++) fs_edge(t);
        vec++;
        if (step !== 3'd5) begin
            miscmp++;
            $display("FAIL pre_off_step: got %0d expected 5", step);
        end
        apu_en  = 1'b0;
        div_bit = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec++;
            if ({step, length_tick, sweep_tick, env_tick} !== 6'b0) begin
                miscmp++;
                $display("FAIL power_off cycle %0d: got %b expected 000000",
                         c, {step, length_tick, sweep_tick, env_tick});
            end
            div_bit = 1'b0;   // falling edge while off must be ignored
        end
        apu_en = 1'b1;
        fs_edge(t);
        vec++;
        if ({t, step} !== {3'b100, 3'd1}) begin
            miscmp++;
            $display("FAIL power_on_first: got ticks=%b step=%0d expected ticks=100 step=1",
                     t, step);
        end
    endtask

    task automatic test_div_write;
        logic [2:0] t;
        int nt;
        fs_edge(t);
        vec++;
        if ({t, step} !== {3'b000, 3'd2}) begin
            miscmp++;
            $display("FAIL dw_setup: got ticks=%b step=%0d expected ticks=000 step=2", t, step);
        end
        div_bit = 1'b1;
        nt = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            nt += int'(length_tick | sweep_tick | env_tick);
        end
        vec++;
        if (nt != 0 || step !== 3'd2) begin
            miscmp++;
            $display("FAIL hold_high: got ticks=%0d step=%0d expected ticks=0 step=2", nt, step);
        end
        div_bit = 1'b0;       // DIV write clears the bit
        @(negedge clk);
        vec++;
        if ({length_tick, sweep_tick, env_tick} !== 3'b110) begin
            miscmp++;
            $display("FAIL div_write_tick: got %b expected 110",
                     {length_tick, sweep_tick, env_tick});
        end
        nt = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            nt += int'(length_tick | sweep_tick | env_tick);
        end
        vec++;
        if (nt != 0 || step !== 3'd3) begin
            miscmp++;
            $display("FAIL hold_low: got ticks=%0d step=%0d expected ticks=0 step=3", nt, step);
        end
    endtask

    task automatic test_async_reset;
        logic [2:0] t;
        fs_edge(t);             // step 3 -> 4, no ticks
        div_bit = 1'b1;
        @(negedge clk);
        div_bit = 1'b0;         // step 4 would register a length tick
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({step, length_tick, sweep_tick, env_tick, len_phase} !== 7'b0) begin
            miscmp++;
            $display("FAIL async_reset_now: got %b expected 0000000",
                     {step, length_tick, sweep_tick, env_tick, len_phase});
        end
        @(negedge clk);
        vec++;
        if ({step, length_tick, sweep_tick, env_tick} !== 6'b0) begin
            miscmp++;
            $display("FAIL async_reset_tick: got %b expected 000000",
                     {step, length_tick, sweep_tick, env_tick});
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({length_tick, sweep_tick, env_tick} !== 3'b000) begin
            miscmp++;
            $display("FAIL post_reset_idle: got %b expected 000",
                     {length_tick, sweep_tick, env_tick});
        end
        fs_edge(t);
        vec++;
        if ({t, step} !== {3'b100, 3'd1}) begin
            miscmp++;
            $display("FAIL post_reset_first: got ticks=%b step=%0d expected ticks=100 step=1",
                     t, step);
        end
    endtask

    // apu_en is live from the negedge in cycle 1; the first event is cycle
    // 8192 and its tick is seen at the negedge of cycle 8193, i.e. 8192
    // negedges later. The next ticking step (step 2) follows two events on.
    task automatic test_intdiv;
        int n;
        n = 0;
        while (length_tick !== 1'b1 && n < 9000) begin
            div_bit = ~div_bit;
            @(negedge clk);
            n++;
        end
        vec++;
        if (n != 8192 || {length_tick, sweep_tick, env_tick} !== 3'b100) begin
            miscmp++;
            $display("FAIL intdiv_first: got n=%0d ticks=%b expected n=8192 ticks=100",
                     n, {length_tick, sweep_tick, env_tick});
        end
        n = 0;
        do begin
            div_bit = ~div_bit;
            @(negedge clk);
            n++;
        end while (!(length_tick | sweep_tick | env_tick) && n < 17000);
        vec++;
        if (n != 16384 || {length_tick, sweep_tick, env_tick} !== 3'b110) begin
            miscmp++;
            $display("FAIL intdiv_next: got n=%0d ticks=%b expected n=16384 ticks=110",
                     n, {length_tick, sweep_tick, env_tick});
        end
    endtask

    initial begin
        test_reset();
`ifdef SOUND_FS_INTDIV_EN
        test_intdiv();
`else
        test_sequence();
        test_counts();
        test_power_off();
        test_div_write();
        test_async_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
